// File: rtl/cache_control.sv
// cache_control: control FSM for the 4-way set-associative L1 cache.
// It sequences hit service, dirty-victim writeback and line allocation against
// physical memory. It drives the datapath strobes and keeps saturating
// hit/miss/writeback counters. The strobes are decoded from the state and the
// live datapath inputs, because a hit has to be answered in the same COMPARE
// cycle in which the tag match is seen.

module cache_control #(
  parameter int NUM_WAYS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mem_read,
  input  logic                        mem_write,
  output logic                        mem_resp,
  input  logic                        hit,
  input  logic [$clog2(NUM_WAYS)-1:0] hit_way,
  input  logic [NUM_WAYS-1:0]         valid_o,
  input  logic [NUM_WAYS-1:0]         dirty_o,
  input  logic [$clog2(NUM_WAYS)-1:0] plru_way,
  output logic                        load_plru,
  output logic [$clog2(NUM_WAYS)-1:0] way_sel,
  output logic                        load_data,
  output logic                        data_in_sel,
  output logic                        load_tag,
  output logic                        set_valid,
  output logic                        set_dirty,
  output logic                        clr_dirty,
  output logic                        pmem_addr_sel,
  output logic                        pmem_read,
  output logic                        pmem_write,
  input  logic                        pmem_resp,
  output logic [CNT_W-1:0]            hit_cnt,
  output logic [CNT_W-1:0]            miss_cnt,
  output logic [CNT_W-1:0]            wb_cnt
);

  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  state_t           state;
  logic [WAY_W-1:0] victim;
  logic             req;
  logic             victim_dirty;

  assign req          = mem_read | mem_write;
  assign victim_dirty = valid_o[plru_way] & dirty_o[plru_way];

  // State sequencing, victim capture on a miss and the saturating counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      victim   <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) state <= COMPARE;
        end
        COMPARE: begin
          if (!req) begin
            state <= IDLE;
          end else if (hit) begin
            if (hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + CNT_ONE;
            state <= IDLE;
          end else begin
            victim <= plru_way;
            if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + CNT_ONE;
            state <= victim_dirty ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            if (wb_cnt != CNT_MAX) wb_cnt <= wb_cnt + CNT_ONE;
            state <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (pmem_resp) state <= COMPARE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobe decode: everything idles at zero unless the current state asks for it.
  always_comb begin
    mem_resp      = 1'b0;
    load_plru     = 1'b0;
    way_sel       = '0;
    load_data     = 1'b0;
    data_in_sel   = 1'b0;
    load_tag      = 1'b0;
    set_valid     = 1'b0;
    set_dirty     = 1'b0;
    clr_dirty     = 1'b0;
    pmem_addr_sel = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    case (state)
      COMPARE: begin
        if (req && hit) begin
          mem_resp  = 1'b1;
          load_plru = 1'b1;
          way_sel   = hit_way;
          if (mem_write) begin
            load_data = 1'b1;
            set_dirty = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        way_sel       = victim;
        if (pmem_resp) clr_dirty = 1'b1;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        way_sel   = victim;
        if (pmem_resp) begin
          load_data   = 1'b1;
          data_in_sel = 1'b1;
          load_tag    = 1'b1;
          set_valid   = 1'b1;
          clr_dirty   = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: directed bench for cache_control with a scoreboard.
// Stimulus pushes the expected CPU completion and expected pmem completions into
// queues; a monitor pops and compares whenever the DUT completes one.

module tb_cache_control;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             mem_read, mem_write, mem_resp;
  logic             hit;
  logic [1:0]       hit_way;
  logic [3:0]       valid_o, dirty_o;
  logic [1:0]       plru_way;
  logic             load_plru;
  logic [1:0]       way_sel;
  logic             load_data, data_in_sel, load_tag, set_valid, set_dirty, clr_dirty;
  logic             pmem_addr_sel, pmem_read, pmem_write, pmem_resp;
  logic [CNT_W-1:0] hit_cnt, miss_cnt, wb_cnt;

  cache_control #(.NUM_WAYS(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .hit(hit), .hit_way(hit_way), .valid_o(valid_o), .dirty_o(dirty_o),
    .plru_way(plru_way), .load_plru(load_plru), .way_sel(way_sel),
    .load_data(load_data), .data_in_sel(data_in_sel), .load_tag(load_tag),
    .set_valid(set_valid), .set_dirty(set_dirty), .clr_dirty(clr_dirty),
    .pmem_addr_sel(pmem_addr_sel), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  typedef struct {
    logic [1:0] way;
    logic       load_data;
    logic       set_dirty;
  } resp_t;

  typedef struct {
    logic       is_wb;
    logic [1:0] way;
  } fill_t;

  resp_t resp_q[$];
  fill_t fill_q[$];

  int checks = 0;
  int errors = 0;
  int exp_hit = 0;
  int exp_miss = 0;
  int exp_wb = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and reports a mismatch with both values.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Monitor: compares each CPU completion and each pmem completion against the queues.
  always @(negedge clk) begin : monitor
    resp_t r;
    fill_t f;
    if (rst) begin
      checkOutput("pmem_exclusive", 32'(pmem_read & pmem_write), 32'd0);
      if (mem_resp) begin
        if (resp_q.size() == 0) begin
          checkOutput("unexpected_mem_resp", 32'd1, 32'd0);
        end else begin
          r = resp_q.pop_front();
          checkOutput("resp_way_sel", 32'(way_sel), 32'(r.way));
          checkOutput("resp_load_plru", 32'(load_plru), 32'd1);
          checkOutput("resp_load_data", 32'(load_data), 32'(r.load_data));
          checkOutput("resp_set_dirty", 32'(set_dirty), 32'(r.set_dirty));
          checkOutput("resp_data_in_sel", 32'(data_in_sel), 32'd0);
          checkOutput("resp_no_pmem", 32'(pmem_read | pmem_write), 32'd0);
        end
      end
      if (pmem_resp && (pmem_read || pmem_write)) begin
        if (fill_q.size() == 0) begin
          checkOutput("unexpected_pmem_xfer", 32'd1, 32'd0);
        end else begin
          f = fill_q.pop_front();
          checkOutput("pmem_write", 32'(pmem_write), 32'(f.is_wb));
          checkOutput("pmem_read", 32'(pmem_read), 32'(!f.is_wb));
          checkOutput("pmem_way_sel", 32'(way_sel), 32'(f.way));
          checkOutput("pmem_addr_sel", 32'(pmem_addr_sel), 32'(f.is_wb));
          checkOutput("pmem_clr_dirty", 32'(clr_dirty), 32'd1);
          checkOutput("fill_load_data", 32'(load_data), 32'(!f.is_wb));
          checkOutput("fill_data_in_sel", 32'(data_in_sel), 32'(!f.is_wb));
          checkOutput("fill_load_tag", 32'(load_tag), 32'(!f.is_wb));
          checkOutput("fill_set_valid", 32'(set_valid), 32'(!f.is_wb));
          checkOutput("pmem_load_plru", 32'(load_plru), 32'd0);
        end
      end
    end
  end

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_hit_cnt"}, 32'(hit_cnt), 32'(exp_hit));
    checkOutput({tag, "_miss_cnt"}, 32'(miss_cnt), 32'(exp_miss));
    checkOutput({tag, "_wb_cnt"}, 32'(wb_cnt), 32'(exp_wb));
  endtask

  // One full CPU access: hit or miss, with optional writeback, pmem delay and a
  // mid-miss change of the PLRU victim.
  task automatic applyStimulus(input logic rd, input logic wr, input logic is_hit,
                               input logic [1:0] way, input logic [3:0] valid,
                               input logic [3:0] dirty, input logic [1:0] mid_way,
                               input int delay, input string tag);
    int   n;
    logic need_wb;
    need_wb = !is_hit && valid[way] && dirty[way];
    resp_q.push_back('{way, wr, wr});
    if (!is_hit) begin
      if (need_wb) fill_q.push_back('{1'b1, way});
      fill_q.push_back('{1'b0, way});
    end
    @(posedge clk); #1;
    mem_read  = rd;
    mem_write = wr;
    hit       = is_hit;
    hit_way   = is_hit ? way : ~way;
    plru_way  = way;
    valid_o   = valid;
    dirty_o   = dirty;
    if (is_hit) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!mem_resp && n < 10);
      checkOutput({tag, "_hit_latency"}, 32'(n), 32'd2);
    end else begin
      if (need_wb) begin
        n = 0;
        do begin @(negedge clk); n++; end while (!pmem_write && n < 10);
        checkOutput({tag, "_wb_start"}, 32'(n), 32'd3);
        @(posedge clk); #1;
        plru_way = mid_way;
        for (int i = 0; i < delay; i++) begin
          @(negedge clk);
          checkOutput({tag, "_wb_hold"}, 32'(pmem_write), 32'd1);
          checkOutput({tag, "_wb_no_read"}, 32'(pmem_read), 32'd0);
          if (i < delay - 1) @(posedge clk);
        end
        @(posedge clk); #1; pmem_resp = 1'b1;
        @(posedge clk); #1; pmem_resp = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!pmem_read && n < 10);
        checkOutput({tag, "_alloc_after_wb"}, 32'(n), 32'd1);
      end else begin
        n = 0;
        do begin @(negedge clk); n++; end while (!pmem_read && n < 10);
        checkOutput({tag, "_alloc_start"}, 32'(n), 32'd3);
      end
      for (int i = 0; i < delay; i++) begin
        if (i > 0) @(negedge clk);
        checkOutput({tag, "_alloc_hold"}, 32'(pmem_read), 32'd1);
        @(posedge clk);
      end
      #1; pmem_resp = 1'b1;
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      hit       = 1'b1;
      hit_way   = way;
      @(negedge clk);
      checkOutput({tag, "_miss_resp_latency"}, 32'(mem_resp), 32'd1);
    end
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    hit       = 1'b0;
    if (!is_hit) begin
      exp_miss = sat_inc(exp_miss);
      if (need_wb) exp_wb = sat_inc(exp_wb);
    end
    exp_hit = sat_inc(exp_hit);
    checkCounters(tag);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int n;
    rst = 1'b0;
    mem_read = 1'b1; mem_write = 1'b0; hit = 1'b1; hit_way = 2'd0;
    valid_o = 4'hF; dirty_o = 4'h0; plru_way = 2'd0; pmem_resp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_mem_resp", 32'(mem_resp), 32'd0);
    checkOutput("reset_pmem", 32'(pmem_read | pmem_write), 32'd0);
    checkOutput("reset_load_plru", 32'(load_plru), 32'd0);
    checkCounters("reset");
    mem_read = 1'b0; hit = 1'b0;
    @(negedge clk); rst = 1'b1;

    applyStimulus(1'b1, 1'b0, 1'b1, 2'd2, 4'hF, 4'h0, 2'd2, 0, "read_hit");
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 4'hF, 4'h0, 2'd1, 0, "write_hit");
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd3, 4'hF, 4'h0, 2'd3, 0, "both_is_write");
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd3, 4'hF, 4'h0, 2'd3, 5, "clean_miss");
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 4'hF, 4'b0001, 2'd2, 4, "dirty_miss");
    applyStimulus(1'b0, 1'b1, 0, 2'd2, 4'hF, 4'b0100, 2'd1, 2, "dirty_write_miss");
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd1, 4'b1101, 4'b0010, 2'd1, 1, "invalid_dirty");

    // pmem_resp while idle must not move the FSM or the counters
    @(posedge clk); #1; pmem_resp = 1'b1;
    @(posedge clk); #1; pmem_resp = 1'b0;
    @(negedge clk);
    checkOutput("idle_pmem_resp_no_read", 32'(pmem_read | pmem_write), 32'd0);
    checkCounters("idle_pmem_resp");

    // request dropped before COMPARE: no strobes, back to IDLE
    @(posedge clk); #1; mem_read = 1'b1; hit = 1'b1; hit_way = 2'd1;
    @(posedge clk); #1; mem_read = 1'b0;
    @(negedge clk);
    checkOutput("dropped_mem_resp", 32'(mem_resp), 32'd0);
    checkOutput("dropped_load_plru", 32'(load_plru), 32'd0);
    @(posedge clk); #1; hit = 1'b0;
    checkCounters("dropped");
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 4'hF, 4'h0, 2'd0, 0, "after_drop");

    // asynchronous reset in the middle of a writeback
    @(posedge clk); #1;
    mem_read = 1'b1; hit = 1'b0; hit_way = 2'd2; plru_way = 2'd1;
    valid_o = 4'hF; dirty_o = 4'b0010;
    n = 0;
    do begin @(negedge clk); n++; end while (!pmem_write && n < 10);
    checkOutput("rst_wb_reached", 32'(pmem_write), 32'd1);
    #2; rst = 1'b0;
    #1;
    checkOutput("rst_pmem_write", 32'(pmem_write), 32'd0);
    checkOutput("rst_pmem_read", 32'(pmem_read), 32'd0);
    mem_read = 1'b0;
    exp_hit = 0; exp_miss = 0; exp_wb = 0;
    checkCounters("mid_wb_reset");
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd3, 4'hF, 4'h0, 2'd3, 0, "post_reset_hit");

    // drive hit_cnt up to all-ones, then one more hit must leave it there
    while (exp_hit < CNT_MAX)
      applyStimulus(1'b1, 1'b0, 1'b1, 2'd1, 4'hF, 4'h0, 2'd1, 0, "sat_fill");
    checkOutput("sat_reached", 32'(hit_cnt), 32'(CNT_MAX));
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd2, 4'hF, 4'h0, 2'd2, 0, "sat_extra");
    checkOutput("sat_hold", 32'(hit_cnt), 32'(CNT_MAX));

    repeat (2) @(posedge clk);
    checkOutput("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    checkOutput("fill_queue_drained", 32'(fill_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
